// File: rtl/jk_bank_sequencer_if.sv
// Command channel into the JK bank sequencer: valid/ready handshake carrying op + per-flop mask.
interface jk_bank_sequencer_if #(
  parameter int N = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_mask;

  modport master (output cmd_valid, output cmd_op, output cmd_mask, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_mask, output cmd_ready);
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of N JK flops: FIFO'd hold/reset/set/toggle commands, shadow Q model.
// Define JK_SEQ_CHECK_EN to add the CHECK state and the sticky q-vs-expected mismatch flags.

module jk_seq_lane (
  input  logic [1:0] op_i,
  input  logic       m_i,
  input  logic       e_i,
  output logic       j_o,
  output logic       k_o,
  output logic       e_nxt_o
);
  assign j_o     = m_i & op_i[1];
  assign k_o     = m_i & op_i[0];
  // JK characteristic equation applied to the shadow bit
  assign e_nxt_o = (j_o & ~e_i) | (~k_o & e_i);
endmodule

module jk_bank_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_bank_sequencer_if.slave   cmd_if,
  output logic [N-1:0]         j_o,
  output logic [N-1:0]         k_o,
  input  logic [N-1:0]         q_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [N-1:0]         expected_o,
  output logic                 err_o,
  output logic [N-1:0]         err_bits_o,
  input  logic                 err_clr_i
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]   op;
    logic [N-1:0] mask;
  } cmd_t;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_DRIVE = 2'd2
`ifdef JK_SEQ_CHECK_EN
    , S_CHECK = 2'd3
`endif
  } state_e;

  state_e       st_q, st_d;
  logic [N-1:0] j_q, j_d, k_q, k_d;
  logic [N-1:0] exp_q, exp_d, enx_q, enx_d;
  logic         done_q, done_d;

  cmd_t         mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         full, empty, push, pop;
  cmd_t         head;

  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign push  = cmd_if.cmd_valid && !full;
  assign head  = mem[rd_q[AW-1:0]];
  assign cmd_if.cmd_ready = !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= '{op: cmd_if.cmd_op, mask: cmd_if.cmd_mask};
  end

  logic [N-1:0] lj, lk, le;
  for (genvar i = 0; i < N; i++) begin : g_lane
    jk_seq_lane u_lane (
      .op_i    (head.op),
      .m_i     (head.mask[i]),
      .e_i     (exp_q[i]),
      .j_o     (lj[i]),
      .k_o     (lk[i]),
      .e_nxt_o (le[i])
    );
  end

  always_comb begin
    st_d   = st_q;
    j_d    = j_q;
    k_d    = k_q;
    exp_d  = exp_q;
    enx_d  = enx_q;
    done_d = 1'b0;
    pop    = 1'b0;
    case (st_q)
      S_INIT: begin
        j_d   = '0;
        k_d   = '0;
        exp_d = '0;
        st_d  = S_IDLE;
      end
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          j_d   = lj;
          k_d   = lk;
          enx_d = le;
          st_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // bank samples j/k on this closing edge, so the shadow advances with it
        j_d   = '0;
        k_d   = '0;
        exp_d = enx_q;
`ifdef JK_SEQ_CHECK_EN
        st_d  = S_CHECK;
`else
        st_d   = S_IDLE;
        done_d = 1'b1;
`endif
      end
`ifdef JK_SEQ_CHECK_EN
      S_CHECK: begin
        st_d   = S_IDLE;
        done_d = 1'b1;
      end
`endif
      default: st_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_INIT;
      j_q    <= '0;
      k_q    <= '1;
      exp_q  <= '0;
      enx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      j_q    <= j_d;
      k_q    <= k_d;
      exp_q  <= exp_d;
      enx_q  <= enx_d;
      done_q <= done_d;
    end
  end

  assign j_o        = j_q;
  assign k_o        = k_q;
  assign expected_o = exp_q;
  assign done_o     = done_q;
  assign busy_o     = (st_q != S_IDLE) || !empty;

`ifdef JK_SEQ_CHECK_EN
  logic         err_q;
  logic [N-1:0] errb_q, mism;
  logic         chk;

  assign chk  = (st_q == S_CHECK);
  assign mism = chk ? (q_i ^ exp_q) : '0;

  // a mismatch in the same cycle as err_clr survives; older bits are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      errb_q <= '0;
    end else begin
      err_q  <= (err_q & ~err_clr_i) | (|mism);
      errb_q <= (err_clr_i ? '0 : errb_q) | mism;
    end
  end

  assign err_o      = err_q;
  assign err_bits_o = errb_q;
`else
  logic unused_chk;
  assign unused_chk = ^{q_i, err_clr_i};
  assign err_o      = 1'b0;
  assign err_bits_o = '0;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural JK bank on j/k/q.
module tb_jk_bank_sequencer;
  localparam int N     = 4;
  localparam int DEPTH = 4;
`ifdef JK_SEQ_CHECK_EN
  localparam int SP    = 3;
  localparam int FULLC = 6;
  localparam bit CHK   = 1'b1;
`else
  localparam int SP    = 2;
  localparam int FULLC = 7;
  localparam bit CHK   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_bank_sequencer_if #(.N(N)) cmd_if ();

  logic [N-1:0] j, k, q, expd, errb;
  logic         busy, done, err;
  logic         err_clr = 1'b0;
  logic [N-1:0] bq = '0;
  logic [N-1:0] stuck0 = '0;

  jk_bank_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_if     (cmd_if.slave),
    .j_o        (j),
    .k_o        (k),
    .q_i        (q),
    .busy_o     (busy),
    .done_o     (done),
    .expected_o (expd),
    .err_o      (err),
    .err_bits_o (errb),
    .err_clr_i  (err_clr)
  );

  // JK bank model
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      case ({j[i], k[i]})
        2'b01:   bq[i] <= 1'b0;
        2'b10:   bq[i] <= 1'b1;
        2'b11:   bq[i] <= ~bq[i];
        default: bq[i] <= bq[i];
      endcase
    end
  end
  assign q = bq & ~stuck0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int dn = 0;
  int dcyc[$];
  logic [N-1:0] dq[$];
  logic [N-1:0] de[$];
  always @(negedge clk) begin
    if (done) begin
      dn = dn + 1;
      dcyc.push_back(cyc);
      dq.push_back(q);
      de.push_back(expd);
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [N-1:0] m);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_mask  = m;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input string tag);
    int t = 0;
    while (dn < tgt && t < 200) begin
      tick();
      t++;
    end
    chk(tag, 32'(dn >= tgt), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 300) begin
      tick();
      t++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  logic [N-1:0] exp_q2 [4];
  int b;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_mask  = '0;
    exp_q2[0] = 4'b0101;
    exp_q2[1] = 4'b0110;
    exp_q2[2] = 4'b0010;
    exp_q2[3] = 4'b0010;

    // reset / INIT
    do_reset();
    chk("init_j",    32'(j), 32'h0);
    chk("init_k",    32'(k), 32'hf);
    chk("init_busy", 32'(busy), 32'd1);
    chk("init_done", 32'(done), 32'd0);
    chk("init_err",  32'(err), 32'd0);
    tick();
    chk("idle_j",    32'(j), 32'h0);
    chk("idle_k",    32'(k), 32'h0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_exp",  32'(expd), 32'h0);
    chk("idle_q",    32'(q), 32'h0);
    chk("idle_errb", 32'(errb), 32'h0);

    // basic stream
    b = dn;
    push(2'b10, 4'b0101);
    push(2'b11, 4'b0011);
    push(2'b01, 4'b0100);
    push(2'b00, 4'b1111);
    wait_done(b + 4, "stream_done");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stream_q%0d", i),   32'(dq[b+i]), 32'(exp_q2[i]));
      chk($sformatf("stream_exp%0d", i), 32'(de[b+i]), 32'(exp_q2[i]));
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("stream_gap%0d", i), 32'(dcyc[b+i+1] - dcyc[b+i]), 32'(SP));
    chk("stream_err", 32'(err), 32'd0);

    // toggle twice restores, mask 0 still retires
    b = dn;
    push(2'b11, 4'b1001);
    wait_done(b + 1, "tog1_done");
    chk("tog1_exp", 32'(expd), 32'b1011);
    chk("tog1_q",   32'(q),    32'b1011);
    push(2'b11, 4'b1001);
    wait_done(b + 2, "tog2_done");
    chk("tog2_exp", 32'(expd), 32'b0010);
    push(2'b11, 4'b0000);
    wait_done(b + 3, "mask0_done");
    chk("mask0_exp", 32'(expd), 32'b0010);
    chk("mask0_q",   32'(q),    32'b0010);

    // FIFO fill: push every cycle from INIT until full
    do_reset();
    b = dn;
    for (int i = 0; i <= FULLC; i++) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = (i == FULLC) ? 2'b10 : 2'b00;
      cmd_if.cmd_mask  = (i == FULLC) ? 4'hf : 4'h0;
      if (i == FULLC - 1) chk("fill_ready_pre",  32'(cmd_if.cmd_ready), 32'd1);
      if (i == FULLC)     chk("fill_ready_full", 32'(cmd_if.cmd_ready), 32'd0);
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    wait_idle("fill_idle");
    repeat (4) tick();
    chk("fill_count", 32'(dn - b), 32'(FULLC));
    chk("fill_exp",   32'(expd), 32'h0);
    chk("fill_q",     32'(q),    32'h0);

    // stuck-at-0 on bit2
    do_reset();
    stuck0 = 4'b0100;
    tick();
    b = dn;
    push(2'b10, 4'b0100);
    wait_done(b + 1, "stuck_done");
    chk("stuck_q",    32'(q),    32'h0);
    chk("stuck_exp",  32'(expd), 32'b0100);
    chk("stuck_err",  32'(err),  32'(CHK));
    chk("stuck_errb", 32'(errb), CHK ? 32'b0100 : 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err",  32'(err),  32'd0);
    chk("clr_errb", 32'(errb), 32'h0);
    stuck0 = '0;

    // reset during DRIVE
    do_reset();
    tick();
    b = dn;
    push(2'b11, 4'b1111);
    push(2'b10, 4'b0001);
    chk("drv_j", 32'(j), 32'hf);
    chk("drv_k", 32'(k), 32'hf);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rstdrv_busy", 32'(busy), 32'd0);
    chk("rstdrv_exp",  32'(expd), 32'h0);
    chk("rstdrv_q",    32'(q),    32'h0);
    repeat (6) tick();
    chk("rstdrv_nodone", 32'(dn - b), 32'd0);
    chk("rstdrv_q2",     32'(q),      32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
